p2p_egress_format_trans: RTL and testbench

//  Converts the p2p forward-down channel (data + 64b head on first beat) into HPC or ETH egress

---
 rtl/p2p_egress_format_trans_pkg.sv | 19 +
 rtl/p2p_egress_format_trans_if.sv | 20 ++
 rtl/p2p_skid_fifo.sv | 51 +++++
 rtl/p2p_egress_format_trans.sv | 189 ++++++++++++++++++
 tb/tb_p2p_egress_format_trans.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/p2p_egress_format_trans_pkg.sv
// Shared definitions for the p2p egress formatter: port-mode encodings
// and the packet FSM state type.
package p2p_egress_format_trans_pkg;

    localparam int         PORT_MODE_WIDTH = 2;
    localparam logic [1:0] HPC_MODE        = 2'd1;
    localparam logic [1:0] ETH_MODE        = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // Egress port select carried with every buffered beat
    localparam logic SEL_HPC = 1'b0;
    localparam logic SEL_ETH = 1'b1;

endpackage

// File: rtl/p2p_egress_format_trans_if.sv
// Egress packet stream (valid/start/end/user/keep/data with ready).
// One instance per tx port; the formatter drives the master side.
interface p2p_egress_format_trans_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 16
);
    localparam int KEEP_W = DATA_W / 8;

    logic              valid;
    logic              start;
    logic              pkt_end;
    logic [USER_W-1:0] user;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, start, pkt_end, user, keep, data, input  ready);
    modport slave  (input  valid, start, pkt_end, user, keep, data, output ready);

endinterface

// File: rtl/p2p_skid_fifo.sv
// Two-entry registered FIFO. in_ready comes from the registered count only,
// so a push is refused for one cycle whenever both entries are occupied.
module p2p_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_q, wr_d, rd_q, rd_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state: write slot, pointers and occupancy
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = in_data;
        wr_d  = wr_q ^ push;
        rd_d  = rd_q ^ pop;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    // Storage and pointer registers; reset empties the buffer and zeroes data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/p2p_egress_format_trans.sv
// Turns the p2p down channel (data + head on first beat) into HPC or ETH
// egress packet beats. Mode and length are captured on the first beat; the
// beat stream then goes through a 2-entry buffer to the selected port.
module p2p_egress_format_trans
    import p2p_egress_format_trans_pkg::*;
#(
    parameter int C_DATA_WIDTH    = 256,
    parameter int KEEP_WIDTH      = C_DATA_WIDTH / 8,
    parameter int DOWN_HEAD_WIDTH = 64,
    parameter int USER_WIDTH      = 16,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_MODE_WIDTH-1:0] iv_port_mode,
    input  logic                       p2p_rx_valid,
    input  logic                       p2p_rx_last,
    input  logic [C_DATA_WIDTH-1:0]    p2p_rx_data,
    input  logic [DOWN_HEAD_WIDTH-1:0] p2p_rx_head,
    output logic                       p2p_rx_ready,
    p2p_egress_format_trans_if.master  hpc_tx,
    p2p_egress_format_trans_if.master  eth_tx,
    output logic                       o_err_len_short,
    output logic                       o_err_len_long,
    output logic [CNT_WIDTH-1:0]       ov_hpc_pkt_cnt,
    output logic [CNT_WIDTH-1:0]       ov_eth_pkt_cnt,
    output logic [CNT_WIDTH-1:0]       ov_drop_pkt_cnt
);

    localparam int EW = 3 + USER_WIDTH + KEEP_WIDTH + C_DATA_WIDTH;

    // Byte enables for a beat given the bytes remaining before it
    function automatic logic [KEEP_WIDTH-1:0] keep_gen(input logic [15:0] rem, input logic last);
        logic [KEEP_WIDTH-1:0] k;
        for (int i = 0; i < KEEP_WIDTH; i++)
            k[i] = !last || (rem == 16'd0) || (i < int'(rem));
        return k;
    endfunction

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [15:0]           rem_q, rem_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  long_seen_q, long_seen_d;
    logic                  err_short_q, err_short_d, err_long_q, err_long_d;
    logic                  rdy_en_q;
    logic [CNT_WIDTH-1:0]  hpc_cnt_q, hpc_cnt_d, eth_cnt_q, eth_cnt_d, drop_cnt_q, drop_cnt_d;

    logic [15:0]           head_len, cur_rem;
    logic                  acc, first, drop_first, cur_sel, push;
    logic [USER_WIDTH-1:0] cur_user;
    logic [EW-1:0]         push_data, head_data;
    logic                  fifo_in_ready, fifo_out_valid, fifo_out_ready, pop;
    logic                  e_sel, e_start, e_end;
    logic [USER_WIDTH-1:0] e_user;
    logic [KEEP_WIDTH-1:0] e_keep;
    logic [C_DATA_WIDTH-1:0] e_data;
    logic                  unused_head;

    assign unused_head  = ^p2p_rx_head[DOWN_HEAD_WIDTH-1:16];
    assign head_len     = p2p_rx_head[15:0];
    assign p2p_rx_ready = rdy_en_q & ((state_q == ST_DROP) | fifo_in_ready);
    assign acc          = p2p_rx_valid & p2p_rx_ready;

    // Packet FSM, length tracking, error detection and packet counters
    always_comb begin
        first       = (state_q == ST_IDLE);
        cur_rem     = first ? head_len : rem_q;
        cur_sel     = first ? (iv_port_mode == ETH_MODE) : sel_q;
        cur_user    = first ? USER_WIDTH'(head_len) : user_q;
        drop_first  = first && (((iv_port_mode != HPC_MODE) && (iv_port_mode != ETH_MODE))
                                || (head_len == 16'd0));
        push        = acc && (state_q != ST_DROP) && !drop_first;
        push_data   = {cur_sel, first, p2p_rx_last, cur_user,
                       keep_gen(cur_rem, p2p_rx_last), p2p_rx_data};
        state_d     = state_q;
        sel_d       = sel_q;
        rem_d       = rem_q;
        user_d      = user_q;
        long_seen_d = long_seen_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        hpc_cnt_d   = hpc_cnt_q;
        eth_cnt_d   = eth_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (drop_first) begin
                        if (p2p_rx_last) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        else             state_d    = ST_DROP;
                    end else begin
                        sel_d       = cur_sel;
                        user_d      = cur_user;
                        long_seen_d = 1'b0;
                        state_d     = p2p_rx_last ? ST_IDLE : ST_FWD;
                    end
                end
                ST_FWD:  if (p2p_rx_last) state_d = ST_IDLE;
                default: if (p2p_rx_last) begin
                    state_d    = ST_IDLE;
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end
            endcase
        end

        if (push) begin
            rem_d       = (cur_rem > 16'(KEEP_WIDTH)) ? cur_rem - 16'(KEEP_WIDTH) : 16'd0;
            err_short_d = p2p_rx_last && (cur_rem > 16'(KEEP_WIDTH));
            // A beat arriving after the length ran out is an overrun; flag once
            if (!first && (cur_rem == 16'd0) && !long_seen_q) begin
                err_long_d  = 1'b1;
                long_seen_d = 1'b1;
            end
        end

        if (pop && e_end) begin
            if (e_sel == SEL_ETH) eth_cnt_d = eth_cnt_q + CNT_WIDTH'(1);
            else                  hpc_cnt_d = hpc_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State, error pulse and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_HPC;
            rem_q       <= '0;
            user_q      <= '0;
            long_seen_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
            hpc_cnt_q   <= '0;
            eth_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rem_q       <= rem_d;
            user_q      <= user_d;
            long_seen_q <= long_seen_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            rdy_en_q    <= 1'b1;
            hpc_cnt_q   <= hpc_cnt_d;
            eth_cnt_q   <= eth_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    p2p_skid_fifo #(.WIDTH(EW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   (push_data),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready),
        .out_data  (head_data)
    );

    assign {e_sel, e_start, e_end, e_user, e_keep, e_data} = head_data;
    assign fifo_out_ready = (e_sel == SEL_ETH) ? eth_tx.ready : hpc_tx.ready;
    assign pop            = fifo_out_valid & fifo_out_ready;

    // Only the selected port sees the head entry; the other stays all-zero
    assign hpc_tx.valid   = fifo_out_valid & (e_sel == SEL_HPC);
    assign hpc_tx.start   = hpc_tx.valid & e_start;
    assign hpc_tx.pkt_end = hpc_tx.valid & e_end;
    assign hpc_tx.user    = hpc_tx.valid ? e_user : '0;
    assign hpc_tx.keep    = hpc_tx.valid ? e_keep : '0;
    assign hpc_tx.data    = hpc_tx.valid ? e_data : '0;

    assign eth_tx.valid   = fifo_out_valid & (e_sel == SEL_ETH);
    assign eth_tx.start   = eth_tx.valid & e_start;
    assign eth_tx.pkt_end = eth_tx.valid & e_end;
    assign eth_tx.user    = eth_tx.valid ? e_user : '0;
    assign eth_tx.keep    = eth_tx.valid ? e_keep : '0;
    assign eth_tx.data    = eth_tx.valid ? e_data : '0;

    assign o_err_len_short = err_short_q;
    assign o_err_len_long  = err_long_q;
    assign ov_hpc_pkt_cnt  = hpc_cnt_q;
    assign ov_eth_pkt_cnt  = eth_cnt_q;
    assign ov_drop_pkt_cnt = drop_cnt_q;

endmodule

// File: tb/tb_p2p_egress_format_trans.sv
// Directed bench for p2p_egress_format_trans: forwarding on both ports,
// keep/user generation, backpressure, drops, length errors, reset.
module tb_p2p_egress_format_trans;
    import p2p_egress_format_trans_pkg::*;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 16;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]    mode;
    logic          rx_valid, rx_last, rx_ready;
    logic [DW-1:0] rx_data;
    logic [63:0]   rx_head;
    logic          err_short, err_long;
    logic [CW-1:0] hpc_cnt, eth_cnt, drop_cnt;

    p2p_egress_format_trans_if #(.DATA_W(DW), .USER_W(UW)) hpc_if ();
    p2p_egress_format_trans_if #(.DATA_W(DW), .USER_W(UW)) eth_if ();

    p2p_egress_format_trans #(
        .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DOWN_HEAD_WIDTH(64), .USER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .iv_port_mode(mode),
        .p2p_rx_valid(rx_valid), .p2p_rx_last(rx_last), .p2p_rx_data(rx_data),
        .p2p_rx_head(rx_head), .p2p_rx_ready(rx_ready),
        .hpc_tx(hpc_if), .eth_tx(eth_if),
        .o_err_len_short(err_short), .o_err_len_long(err_long),
        .ov_hpc_pkt_cnt(hpc_cnt), .ov_eth_pkt_cnt(eth_cnt), .ov_drop_pkt_cnt(drop_cnt)
    );

    // Egress beat capture
    logic [DW-1:0] h_data[64], e_data[64];
    logic [KW-1:0] h_keep[64], e_keep[64];
    logic [UW-1:0] h_user[64], e_user[64];
    logic          h_start[64], h_end[64], e_start[64], e_end[64];
    int nh = 0, ne = 0, eth_vld_cyc = 0, long_seen = 0, short_seen = 0;

    always @(posedge clk) begin
        if (hpc_if.valid && hpc_if.ready && nh < 64) begin
            h_data[nh] <= hpc_if.data; h_keep[nh] <= hpc_if.keep; h_user[nh] <= hpc_if.user;
            h_start[nh] <= hpc_if.start; h_end[nh] <= hpc_if.pkt_end; nh <= nh + 1;
        end
        if (eth_if.valid && eth_if.ready && ne < 64) begin
            e_data[ne] <= eth_if.data; e_keep[ne] <= eth_if.keep; e_user[ne] <= eth_if.user;
            e_start[ne] <= eth_if.start; e_end[ne] <= eth_if.pkt_end; ne <= ne + 1;
        end
        if (eth_if.valid) eth_vld_cyc <= eth_vld_cyc + 1;
        if (err_long)     long_seen   <= long_seen + 1;
        if (err_short)    short_seen  <= short_seen + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int p, input int b);
        logic [31:0] w;
        w = {16'(p), 16'(b)};
        return {8{w}};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic send(input logic last, input logic [DW-1:0] d);
        int   n;
        logic a;
        n = 0;
        rx_valid = 1'b1; rx_last = last; rx_data = d;
        do begin
            a = rx_ready;
            @(posedge clk); #1;
            n++;
        end while (!a && n < 50);
        chk("send_accept", a, 1'b1);
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bh, be, lb, sb;
        rst_n = 1'b0; mode = HPC_MODE; rx_valid = 1'b0; rx_last = 1'b0;
        rx_data = '0; rx_head = '0; hpc_if.ready = 1'b1; eth_if.ready = 1'b1;
        idle(2);
        // Reset state
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_hpc_valid", hpc_if.valid, 1'b0);
        chk("rst_eth_valid", eth_if.valid, 1'b0);
        chk("rst_hpc_cnt", hpc_cnt, 0);
        chk("rst_errs", {err_short, err_long}, 2'b00);
        rst_n = 1'b1;
        idle(1);
        chk("rst_rel_ready", rx_ready, 1'b1);

        // 1: HPC, len 64, 2 beats
        bh = nh;
        mode = HPC_MODE; rx_head = 64'd64;
        send(1'b0, beat(1, 0));
        chk("t1_latency", {hpc_if.valid, hpc_if.start}, 2'b11);
        rx_head = 64'd5;
        send(1'b1, beat(1, 1));
        idle(3);
        chk("t1_nbeats", nh - bh, 2);
        chk("t1_se0", {h_start[bh], h_end[bh]}, 2'b10);
        chk("t1_se1", {h_start[bh+1], h_end[bh+1]}, 2'b01);
        chk("t1_keep0", h_keep[bh], 32'hFFFF_FFFF);
        chk("t1_keep1", h_keep[bh+1], 32'hFFFF_FFFF);
        chk("t1_user1", h_user[bh+1], 64);
        chk("t1_data1", h_data[bh+1], beat(1, 1));
        chk("t1_eth_quiet", eth_vld_cyc, 0);
        chk("t1_hpc_cnt", hpc_cnt, 1);

        // 2: ETH, len 70, 3 beats
        be = ne;
        mode = ETH_MODE; rx_head = 64'd70;
        send(1'b0, beat(2, 0)); send(1'b0, beat(2, 1)); send(1'b1, beat(2, 2));
        idle(3);
        chk("t2_nbeats", ne - be, 3);
        chk("t2_keep0", e_keep[be], 32'hFFFF_FFFF);
        chk("t2_keep2", e_keep[be+2], 32'h0000_003F);
        chk("t2_user2", e_user[be+2], 70);
        chk("t2_end2", e_end[be+2], 1'b1);
        chk("t2_eth_cnt", eth_cnt, 1);
        chk("t2_no_err", long_seen + short_seen, 0);

        // 3: mode flips mid-packet; the packet stays on HPC
        bh = nh; be = ne;
        mode = HPC_MODE; rx_head = 64'd64;
        send(1'b0, beat(3, 0));
        mode = ETH_MODE;
        send(1'b1, beat(3, 1));
        idle(3);
        chk("t3_hpc_beats", nh - bh, 2);
        chk("t3_eth_beats", ne - be, 0);
        chk("t3_hpc_cnt", hpc_cnt, 2);
        rx_head = 64'd10;
        send(1'b1, beat(3, 2));
        idle(3);
        chk("t3_eth_se", {e_start[be], e_end[be]}, 2'b11);
        chk("t3_eth_keep", e_keep[be], 32'h0000_03FF);
        chk("t3_eth_user", e_user[be], 10);
        chk("t3_eth_cnt", eth_cnt, 2);

        // 4: HPC stalled 5 cycles during an 8-beat packet
        bh = nh;
        mode = HPC_MODE; rx_head = 64'd256; hpc_if.ready = 1'b0;
        send(1'b0, beat(4, 0)); send(1'b0, beat(4, 1));
        chk("t4_full_ready", rx_ready, 1'b0);
        rx_valid = 1'b1; rx_data = beat(4, 2);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_stall_vld", {hpc_if.valid, hpc_if.start, rx_ready}, 3'b110);
            chk("t4_stall_data", hpc_if.data, beat(4, 0));
        end
        hpc_if.ready = 1'b1;
        for (int i = 2; i < 8; i++) send(i == 7, beat(4, i));
        idle(4);
        chk("t4_nbeats", nh - bh, 8);
        for (int i = 0; i < 8; i++) chk("t4_data", h_data[bh+i], beat(4, i));
        chk("t4_end7", {h_end[bh+6], h_end[bh+7]}, 2'b01);
        chk("t4_keep7", h_keep[bh+7], 32'hFFFF_FFFF);
        chk("t4_hpc_cnt", hpc_cnt, 3);

        // 5: invalid mode, then zero length -> dropped
        bh = nh; be = ne;
        mode = 2'd3; rx_head = 64'd64;
        send(1'b0, beat(5, 0));
        chk("t5_drop_ready", rx_ready, 1'b1);
        send(1'b0, beat(5, 1)); send(1'b1, beat(5, 2));
        idle(2);
        chk("t5_drop_cnt1", drop_cnt, 1);
        mode = HPC_MODE; rx_head = 64'd0;
        send(1'b0, beat(5, 3)); send(1'b0, beat(5, 4)); send(1'b1, beat(5, 5));
        idle(3);
        chk("t5_drop_cnt2", drop_cnt, 2);
        chk("t5_nothing", (nh - bh) + (ne - be), 0);

        // 6: overrun (len 40 in 3 beats), short (len 100 in 2 beats)
        bh = nh; lb = long_seen; sb = short_seen;
        rx_head = 64'd40;
        send(1'b0, beat(6, 0)); send(1'b0, beat(6, 1));
        chk("t6_long_b2", err_long, 1'b0);
        send(1'b1, beat(6, 2));
        chk("t6_long_b3", err_long, 1'b1);
        idle(3);
        chk("t6_long_once", long_seen - lb, 1);
        chk("t6_keep_rem0", h_keep[bh+2], 32'hFFFF_FFFF);
        rx_head = 64'd100;
        send(1'b0, beat(6, 3));
        chk("t6_short_b1", err_short, 1'b0);
        send(1'b1, beat(6, 4));
        chk("t6_short_b2", err_short, 1'b1);
        idle(3);
        chk("t6_short_once", short_seen - sb, 1);
        chk("t6_fwd_beats", nh - bh, 5);

        // Reset in the middle of a packet
        hpc_if.ready = 1'b0; rx_head = 64'd64;
        send(1'b0, beat(7, 0));
        chk("t7_pre_vld", hpc_if.valid, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("t7_rst_vld", {hpc_if.valid, hpc_if.start, rx_ready}, 3'b000);
        chk("t7_rst_data", hpc_if.data, '0);
        chk("t7_rst_cnts", {hpc_cnt, drop_cnt}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1; hpc_if.ready = 1'b1;
        idle(1);
        chk("t7_rel_ready", rx_ready, 1'b1);
        bh = nh; rx_head = 64'd16;
        send(1'b1, beat(8, 0));
        idle(3);
        chk("t7_nbeats", nh - bh, 1);
        chk("t7_se", {h_start[bh], h_end[bh]}, 2'b11);
        chk("t7_keep", h_keep[bh], 32'h0000_FFFF);
        chk("t7_user", h_user[bh], 16);
        chk("t7_data", h_data[bh], beat(8, 0));
        chk("t7_hpc_cnt", hpc_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
